// File: rtl/uart_tx_frame.sv
// UART transmit frame engine: start bit, DATA_WIDTH data bits LSB first, optional
// parity bit and one stop bit, one line bit per clock. TX_OUT and Busy are registered.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_out_q, tx_out_d;
    logic                  busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_out_q  <= tx_out_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;

        case (state_q)
            IDLE: begin
                if (DATA_VALID) begin
                    state_d   = START;
                    shift_d   = P_DATA;
                    par_en_d  = PAR_EN;
                    par_bit_d = PAR_TYP ? ~^P_DATA : ^P_DATA;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            PARITY:  state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Line level is decoded from the next state so the output flop carries
    // exactly the bit of the state being entered.
    always_comb begin
        tx_out_d = 1'b1;
        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_d[cnt_d];
            PARITY:  tx_out_d = par_bit_d;
            default: tx_out_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign TX_OUT = tx_out_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: expected line-bit frames are queued by the driver
// and a negedge monitor compares every Busy cycle and every idle cycle against them.
module tb_uart_tx_frame;

    logic       clk;
    logic       reset;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    int          len_q[$];
    int          start_cyc[$];

    logic        mon_en   = 1'b0;
    logic        in_frame = 1'b0;
    logic [15:0] cur      = '0;
    int          cur_len  = 0;
    int          idx      = 0;
    int          cyc      = 0;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // push a hand-written frame: string characters are line bits in time order
    task automatic push_frame(input string bits);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < bits.len(); i++) v[i] = (bits[i] == "1");
        exp_q.push_back(v);
        len_q.push_back(bits.len());
    endtask

    // called at a negedge; waits for idle, then strobes DATA_VALID for one edge
    task automatic send(input logic [7:0] d, input logic pen, input logic ptyp, input string bits);
        int guard;
        guard = 0;
        while (Busy !== 1'b0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) begin
            total++;
            bad++;
            $display("FAIL send_wait: Busy=%b still high after %0d cycles, required 0", Busy, guard);
        end
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        DATA_VALID = 1'b1;
        push_frame(bits);
        @(posedge clk);
        @(negedge clk);
        DATA_VALID = 1'b0;
        P_DATA     = 8'($urandom_range(0, 255));
        PAR_EN     = 1'($urandom_range(0, 1));
        PAR_TYP    = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((Busy !== 1'b0 || in_frame) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) begin
            total++;
            bad++;
            $display("FAIL idle_wait: Busy=%b after %0d cycles, required 0", Busy, guard);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (Busy === 1'b1) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    idx      = 0;
                    start_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        cur_len = 0;
                        $display("FAIL unexpected_frame: Busy rose at cycle %0d with no queued frame", cyc);
                    end else begin
                        cur     = exp_q.pop_front();
                        cur_len = len_q.pop_front();
                    end
                end
                total++;
                if (idx >= cur_len) begin
                    bad++;
                    $display("FAIL busy_long: Busy=1 at frame bit %0d, required frame length %0d", idx, cur_len);
                end else if (TX_OUT !== cur[idx]) begin
                    bad++;
                    $display("FAIL line_bit: bit %0d TX_OUT=%b, required %b", idx, TX_OUT, cur[idx]);
                end
                idx++;
            end else begin
                total++;
                if (Busy !== 1'b0 || TX_OUT !== 1'b1) begin
                    bad++;
                    $display("FAIL idle_line: Busy=%b TX_OUT=%b, required Busy=0 TX_OUT=1", Busy, TX_OUT);
                end
                if (in_frame) begin
                    in_frame = 1'b0;
                    total++;
                    if (idx != cur_len) begin
                        bad++;
                        $display("FAIL frame_len: Busy high %0d cycles, required %0d", idx, cur_len);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        reset      = 1'b1;
        P_DATA     = 8'h00;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;

        // reset held 2 cycles; monitor checks idle line from the first reset edge on
        @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        send(8'hA5, 1'b1, 1'b0, "01010010101");
        send(8'hA5, 1'b1, 1'b1, "01010010111");
        send(8'h01, 1'b1, 1'b1, "01000000001");
        send(8'h01, 1'b1, 1'b0, "01000000011");
        send(8'h3C, 1'b0, 1'b0, "0001111001");
        send(8'h00, 1'b1, 1'b1, "00000000011");
        send(8'h80, 1'b0, 1'b1, "0000000011");

        // mid-frame input changes and a dropped DATA_VALID pulse
        send(8'h5A, 1'b0, 1'b0, "0010110101");
        repeat (3) @(negedge clk);
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b1;
        DATA_VALID = 1'b1;
        @(negedge clk);
        DATA_VALID = 1'b0;
        wait_idle();

        // DATA_VALID held high: two frames with one idle bit between them
        n = start_cyc.size();
        P_DATA     = 8'hC3;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        DATA_VALID = 1'b1;
        push_frame("01100001101");
        push_frame("01100001101");
        for (int g = 0; g < 60 && start_cyc.size() < n + 2; g++) @(negedge clk);
        DATA_VALID = 1'b0;
        total++;
        if (start_cyc.size() < n + 2) begin
            bad++;
            $display("FAIL b2b_frames: saw %0d frame starts, required 2", start_cyc.size() - n);
        end else if (start_cyc[n+1] - start_cyc[n] != 12) begin
            bad++;
            $display("FAIL b2b_spacing: accept spacing %0d cycles, required 12", start_cyc[n+1] - start_cyc[n]);
        end
        wait_idle();

        // reset during data bit 4 of 0xFF: only start + d0..d4 reach the line
        send(8'hFF, 1'b1, 1'b0, "011111");
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort: TX_OUT=%b Busy=%b, required TX_OUT=1 Busy=0", TX_OUT, Busy);
        end
        reset = 1'b0;
        send(8'h96, 1'b1, 1'b1, "00110100111");
        wait_idle();

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: %0d frames left, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
